// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I/Zicsr decode stage with a DEPTH-entry decoded FIFO and load-use interlock.
// Optional macro CSR_SET_CLR_EN enables CSRRS/CSRRC/CSRRSI/CSRRCI decode.
module decode_ctrl_pipe #(
  parameter int PC_WIDTH       = 32,
  parameter int DEPTH          = 2,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic                reg_wen,
  output logic                br_un,
  output logic                a_sel,
  output logic                b_sel,
  output logic                csr_wen,
  output logic [2:0]          imm_sel,
  output logic [2:0]          csr_sel,
  output logic [3:0]          alu_sel,
  output logic [1:0]          wb_sel,
  output logic [1:0]          csr_op,
  output logic                illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_C = SW'(LOAD_USE_STALL);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_BSEL = 4'd10;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_SYS = 7'b1110011;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                reg_wen;
    logic                br_un;
    logic                a_sel;
    logic                b_sel;
    logic                csr_wen;
    logic [2:0]          imm_sel;
    logic [2:0]          csr_sel;
    logic [3:0]          alu_sel;
    logic [1:0]          wb_sel;
    logic [1:0]          csr_op;
    logic                illegal;
    logic                is_load;
    logic                use_rs1;
    logic                use_rs2;
  } entry_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  entry_t     dec_d;
  entry_t     mem_q [DEPTH];
  entry_t     head;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q;
  logic [SW-1:0] stall_q;
  logic [4:0]    hz_rd_q;
  logic          push, pop, nz, hold;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = pc;
    dec_d.rd      = inst[11:7];
    dec_d.rs1     = inst[19:15];
    dec_d.rs2     = inst[24:20];
    dec_d.alu_sel = ALU_ADD;
    dec_d.b_sel   = 1'b1;
    dec_d.use_rs1 = 1'b1;
    case (opc)
      OPC_OP: begin
        dec_d.reg_wen = 1'b1;
        dec_d.b_sel   = 1'b0;
        dec_d.use_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_d.alu_sel = ALU_ADD;
            3'b001:  dec_d.alu_sel = ALU_SLL;
            3'b010:  dec_d.alu_sel = ALU_SLT;
            3'b011:  dec_d.alu_sel = ALU_SLTU;
            3'b100:  dec_d.alu_sel = ALU_XOR;
            3'b101:  dec_d.alu_sel = ALU_SRL;
            3'b110:  dec_d.alu_sel = ALU_OR;
            default: dec_d.alu_sel = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) dec_d.alu_sel = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)     dec_d.alu_sel = ALU_SRA;
        else dec_d.illegal = 1'b1;
      end
      OPC_IMM: begin
        dec_d.reg_wen = 1'b1;
        case (f3)
          3'b000:  dec_d.alu_sel = ALU_ADD;
          3'b010:  dec_d.alu_sel = ALU_SLT;
          3'b011:  dec_d.alu_sel = ALU_SLTU;
          3'b100:  dec_d.alu_sel = ALU_XOR;
          3'b110:  dec_d.alu_sel = ALU_OR;
          3'b111:  dec_d.alu_sel = ALU_AND;
          3'b001: begin
            dec_d.alu_sel = ALU_SLL;
            dec_d.illegal = (f7 != 7'b0000000);
          end
          default: begin
            if (f7 == 7'b0000000)      dec_d.alu_sel = ALU_SRL;
            else if (f7 == 7'b0100000) dec_d.alu_sel = ALU_SRA;
            else                       dec_d.illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        dec_d.reg_wen = 1'b1;
        dec_d.wb_sel  = 2'b01;
        dec_d.is_load = 1'b1;
      end
      OPC_STORE: begin
        dec_d.imm_sel = 3'b001;
        dec_d.use_rs2 = 1'b1;
      end
      OPC_BR: begin
        dec_d.imm_sel = 3'b010;
        dec_d.a_sel   = 1'b1;
        dec_d.br_un   = (f3[2:1] == 2'b11);
        dec_d.use_rs2 = 1'b1;
        dec_d.illegal = (f3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        dec_d.reg_wen = 1'b1;
        dec_d.a_sel   = 1'b1;
        dec_d.imm_sel = 3'b100;
        dec_d.wb_sel  = 2'b10;
        dec_d.use_rs1 = 1'b0;
      end
      OPC_JALR: begin
        dec_d.reg_wen = 1'b1;
        dec_d.wb_sel  = 2'b10;
      end
      OPC_LUI: begin
        dec_d.reg_wen = 1'b1;
        dec_d.imm_sel = 3'b011;
        dec_d.alu_sel = ALU_BSEL;
        dec_d.use_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        dec_d.reg_wen = 1'b1;
        dec_d.a_sel   = 1'b1;
        dec_d.imm_sel = 3'b011;
        dec_d.use_rs1 = 1'b0;
      end
      OPC_SYS: begin
        dec_d.use_rs1 = ~f3[2];
        dec_d.imm_sel = 3'b101;
        dec_d.wb_sel  = 2'b11;
        dec_d.reg_wen = (inst[11:7] != 5'd0);
        dec_d.csr_sel = {2'b00, f3[2]};
        case (f3[1:0])
          2'b01: begin
            dec_d.csr_wen = 1'b1;
            dec_d.csr_op  = 2'b01;
          end
`ifdef CSR_SET_CLR_EN
          2'b10, 2'b11: begin
            dec_d.csr_op  = f3[1:0];
            dec_d.csr_wen = (inst[19:15] != 5'd0);
          end
`endif
          default: dec_d.illegal = 1'b1;
        endcase
      end
      default: dec_d.illegal = 1'b1;
    endcase
    // Illegal entries fall back to a harmless ADD with no architectural writes.
    if (dec_d.illegal) begin
      dec_d.reg_wen = 1'b0;
      dec_d.csr_wen = 1'b0;
      dec_d.br_un   = 1'b0;
      dec_d.a_sel   = 1'b0;
      dec_d.b_sel   = 1'b1;
      dec_d.imm_sel = 3'b000;
      dec_d.csr_sel = 3'b000;
      dec_d.alu_sel = ALU_ADD;
      dec_d.wb_sel  = 2'b00;
      dec_d.csr_op  = 2'b00;
      dec_d.is_load = 1'b0;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign nz   = (cnt_q != '0);
  assign hold = (stall_q != '0) &&
                ((head.use_rs1 && head.rs1 == hz_rd_q) || (head.use_rs2 && head.rs2 == hz_rd_q));
  assign out_valid = nz && !hold;
  assign in_ready  = in_ready_q;
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      hz_rd_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d < DEPTH_C);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        stall_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (pop && head.is_load && head.rd != 5'd0) begin
          stall_q <= STALL_C;
          hz_rd_q <= head.rd;
        end else if (stall_q != '0) begin
          stall_q <= stall_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_d;
  end

  assign out_pc  = nz ? head.pc      : '0;
  assign rd      = nz ? head.rd      : '0;
  assign rs1     = nz ? head.rs1     : '0;
  assign rs2     = nz ? head.rs2     : '0;
  assign reg_wen = nz & head.reg_wen;
  assign br_un   = nz & head.br_un;
  assign a_sel   = nz & head.a_sel;
  assign b_sel   = nz & head.b_sel;
  assign csr_wen = nz & head.csr_wen;
  assign imm_sel = nz ? head.imm_sel : '0;
  assign csr_sel = nz ? head.csr_sel : '0;
  assign alu_sel = nz ? head.alu_sel : '0;
  assign wb_sel  = nz ? head.wb_sel  : '0;
  assign csr_op  = nz ? head.csr_op  : '0;
  assign illegal = nz & head.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode table plus handshake, hazard, flush and reset sequences.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, out_pc;
  logic [4:0]  rd, rs1, rs2;
  logic        reg_wen, br_un, a_sel, b_sel, csr_wen, illegal;
  logic [2:0]  imm_sel, csr_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel, csr_op;
  logic [19:0] ctl_act;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7, BSEL = 4'd10;
  localparam logic [19:0] ILL = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 4'd0, 2'b00, 2'b00, 1'b1};

  decode_ctrl_pipe #(.PC_WIDTH(32), .DEPTH(2), .LOAD_USE_STALL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .reg_wen(reg_wen), .br_un(br_un), .a_sel(a_sel),
    .b_sel(b_sel), .csr_wen(csr_wen), .imm_sel(imm_sel), .csr_sel(csr_sel),
    .alu_sel(alu_sel), .wb_sel(wb_sel), .csr_op(csr_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign ctl_act = {reg_wen, br_un, a_sel, b_sel, csr_wen, imm_sel, csr_sel, alu_sel, wb_sel, csr_op, illegal};

  typedef struct packed {
    logic [31:0] inst;
    logic [19:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic logic [19:0] ctl(input logic rw, bu, as, bs, cw, input logic [2:0] is, cs,
                                      input logic [3:0] al, input logic [1:0] wb, co, input logic il);
    return {rw, bu, as, bs, cw, is, cs, al, wb, co, il};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    vecs[0]  = '{32'h002081B3, ctl(1,0,0,0,0,3'b000,3'b000,ADD,2'b00,2'b00,0)};
    vecs[1]  = '{32'h402081B3, ctl(1,0,0,0,0,3'b000,3'b000,SUB,2'b00,2'b00,0)};
    vecs[2]  = '{32'h4020D1B3, ctl(1,0,0,0,0,3'b000,3'b000,SRA,2'b00,2'b00,0)};
    vecs[3]  = '{32'h022081B3, ILL};
    vecs[4]  = '{32'h402091B3, ILL};
    vecs[5]  = '{32'h00500093, ctl(1,0,0,1,0,3'b000,3'b000,ADD,2'b00,2'b00,0)};
    vecs[6]  = '{32'h4030D093, ctl(1,0,0,1,0,3'b000,3'b000,SRA,2'b00,2'b00,0)};
    vecs[7]  = '{32'h40309093, ILL};
    vecs[8]  = '{32'h0000A103, ctl(1,0,0,1,0,3'b000,3'b000,ADD,2'b01,2'b00,0)};
    vecs[9]  = '{32'h0020A223, ctl(0,0,0,1,0,3'b001,3'b000,ADD,2'b00,2'b00,0)};
    vecs[10] = '{32'h0020E463, ctl(0,1,1,1,0,3'b010,3'b000,ADD,2'b00,2'b00,0)};
    vecs[11] = '{32'h0020A463, ILL};
    vecs[12] = '{32'h123452B7, ctl(1,0,0,1,0,3'b011,3'b000,BSEL,2'b00,2'b00,0)};
    vecs[13] = '{32'h00001297, ctl(1,0,1,1,0,3'b011,3'b000,ADD,2'b00,2'b00,0)};
    vecs[14] = '{32'h010000EF, ctl(1,0,1,1,0,3'b100,3'b000,ADD,2'b10,2'b00,0)};
    vecs[15] = '{32'h00008067, ctl(1,0,0,1,0,3'b000,3'b000,ADD,2'b10,2'b00,0)};
    vecs[16] = '{32'h30009173, ctl(1,0,0,1,1,3'b101,3'b000,ADD,2'b11,2'b01,0)};
    vecs[17] = '{32'h3002D073, ctl(0,0,0,1,1,3'b101,3'b001,ADD,2'b11,2'b01,0)};
`ifdef CSR_SET_CLR_EN
    vecs[18] = '{32'h0020A173, ctl(1,0,0,1,1,3'b101,3'b000,ADD,2'b11,2'b10,0)};
    vecs[19] = '{32'h00203173, ctl(1,0,0,1,0,3'b101,3'b000,ADD,2'b11,2'b11,0)};
`else
    vecs[18] = '{32'h0020A173, ILL};
    vecs[19] = '{32'h00203173, ILL};
`endif
    vecs[20] = '{32'h00000073, ILL};
    vecs[21] = '{32'h0000007F, ILL};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_ctl", ctl_act, 0);
    rst_n = 1'b1;
    tick();

    // Decode table, one instruction at a time
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      w = vecs[i].inst;
      inst = w; pc = 32'h1000 + i * 4; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_ctl", i), ctl_act, vecs[i].exp);
      chk($sformatf("vec%0d_pc", i), out_pc, 32'h1000 + i * 4);
      chk($sformatf("vec%0d_regs", i), {rd, rs1, rs2}, {w[11:7], w[19:15], w[24:20]});
      tick();
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
    end
    tick();

    // Back-to-back add then sub
    inst = 32'h002081B3; in_valid = 1'b1;
    tick();
    chk("b2b_add_valid", out_valid, 1);
    chk("b2b_add_alu", alu_sel, ADD);
    inst = 32'h402081B3;
    tick();
    in_valid = 1'b0;
    chk("b2b_sub_valid", out_valid, 1);
    chk("b2b_sub_alu", alu_sel, SUB);
    tick();
    chk("b2b_empty", out_valid, 0);

    // Backpressure with three pushes into a two-deep FIFO
    out_ready = 1'b0; in_valid = 1'b1;
    inst = 32'h00100293;
    tick();
    chk("bp_ready_after1", in_ready, 1);
    inst = 32'h00200313;
    tick();
    chk("bp_ready_full", in_ready, 0);
    inst = 32'h00300393;
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_head0", rd, 5);
    out_ready = 1'b1;
    tick();
    chk("bp_head1", rd, 6);
    chk("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_head2", rd, 7);
    chk("bp_head2_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);
    tick();

    // Load-use: dependent add sees one bubble
    inst = 32'h0000A103; in_valid = 1'b1;
    tick();
    chk("lu_load_valid", out_valid, 1);
    inst = 32'h002081B3;
    tick();
    in_valid = 1'b0;
    chk("lu_bubble", out_valid, 0);
    tick();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", rd, 3);
    tick();
    chk("lu_empty", out_valid, 0);
    tick(); tick();

    // Load followed by independent add: no bubble
    inst = 32'h0000A103; in_valid = 1'b1;
    tick();
    inst = 32'h004081B3;
    tick();
    in_valid = 1'b0;
    chk("lu_indep_valid", out_valid, 1);
    chk("lu_indep_rs2", rs2, 4);
    tick();
    chk("lu_indep_empty", out_valid, 0);
    tick(); tick();

    // Flush while full with a concurrent push
    out_ready = 1'b0; in_valid = 1'b1;
    inst = 32'h00100293;
    tick();
    inst = 32'h00200313;
    tick();
    chk("fl_full", in_ready, 0);
    inst = 32'h00300393; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    tick();
    chk("fl_push_lost", out_valid, 0);
    inst = 32'h00400413; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fl_new_entry", rd, 8);
    out_ready = 1'b1;
    tick();
    chk("fl_new_drained", out_valid, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    inst = 32'h00100293;
    tick();
    inst = 32'h00200313;
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_ctl", ctl_act, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_no_stale", out_valid, 0);
    chk("rst_ready_after", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
